// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with synchronous reads, optional write bypass
// and a per-register pending-write scoreboard for RAW hazard stalls.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy_a,
    output logic                  busy_b,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    logic                  wr_eff;
    logic                  rsv_eff;
    logic                  count_inc;
    logic                  count_dec;
    logic [DATA_WIDTH-1:0] rd_a_nxt;
    logic [DATA_WIDTH-1:0] rd_b_nxt;
    logic                  busy_a_nxt;
    logic                  busy_b_nxt;

    // Register 0 swallows writes and reservations when it is hardwired to zero.
    assign wr_eff  = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
    assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_comb begin
        busy_nxt = busy;
        if (wr_eff) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // A same-address reserve cancels the release, so the count only drops
    // when the completing producer is not replaced.
    assign count_inc = rsv_eff && !busy[rsv_addr];
    assign count_dec = wr_eff && busy[wr_addr] && !(rsv_eff && (rsv_addr == wr_addr));

    always_comb begin
        rd_a_nxt = regs[rd_addr_a];
        if ((BYPASS != 0) && wr_eff && (wr_addr == rd_addr_a)) begin
            rd_a_nxt = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_a_nxt = '0;
        end

        rd_b_nxt = regs[rd_addr_b];
        if ((BYPASS != 0) && wr_eff && (wr_addr == rd_addr_b)) begin
            rd_b_nxt = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_b_nxt = '0;
        end

        busy_a_nxt = busy[rd_addr_a] && !(wr_eff && (wr_addr == rd_addr_a));
        busy_b_nxt = busy[rd_addr_b] && !(wr_eff && (wr_addr == rd_addr_b));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_eff) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= busy_count + {{ADDR_WIDTH{1'b0}}, count_inc}
                                     - {{ADDR_WIDTH{1'b0}}, count_dec};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            busy_a    <= 1'b0;
            busy_b    <= 1'b0;
        end else if (rd_en) begin
            rd_data_a <= rd_a_nxt;
            rd_data_b <= rd_b_nxt;
            busy_a    <= busy_a_nxt;
            busy_b    <= busy_b_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic,
// checked every cycle against an array-based model of the register file.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int ZR    = 1;
    localparam int BP    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          busy_a;
    logic          busy_b;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rsv_en = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    logic [AW:0]   busy_count;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    logic [DW-1:0] m_rd_a, m_rd_b;
    bit            m_busy_a, m_busy_b;
    int            m_count;

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(BP)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_count(busy_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_rd_a = '0; m_rd_b = '0;
        m_busy_a = 1'b0; m_busy_b = 1'b0;
        m_count = 0;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit we);
        if (ZR != 0 && a == 0) return '0;
        if (BP != 0 && we && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    // Reads observe the pre-edge state; the write then lands, then the reserve.
    task automatic model_step();
        bit we, re;
        int n;
        we = wr_en && !(ZR != 0 && wr_addr == 0);
        re = rsv_en && !(ZR != 0 && rsv_addr == 0);
        if (rd_en) begin
            m_rd_a   = model_read(rd_addr_a, we);
            m_rd_b   = model_read(rd_addr_b, we);
            m_busy_a = m_busy[rd_addr_a] && !(we && wr_addr == rd_addr_a);
            m_busy_b = m_busy[rd_addr_b] && !(we && wr_addr == rd_addr_b);
        end
        if (we) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (re) m_busy[rsv_addr] = 1'b1;
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        m_count = n;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n && compare_on) begin
            check("cmp_rd_data_a", rd_data_a, m_rd_a);
            check("cmp_rd_data_b", rd_data_b, m_rd_b);
            check("cmp_busy_a", busy_a, m_busy_a);
            check("cmp_busy_b", busy_b, m_busy_b);
            check("cmp_busy_count", busy_count, m_count);
        end
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy_count", busy_count, 0);
        check("rst_rd_data_a", rd_data_a, 0);
        reset_n = 1'b1;
        compare_on = 1'b1;

        // Every index reads zero after reset.
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH - 1 - i);
            tick();
            check("rst_read_a", rd_data_a, 0);
            check("rst_read_b", rd_data_b, 0);
            check("rst_read_busy", {busy_a, busy_b}, 0);
        end
        check("rst_read_count", busy_count, 0);

        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        tick();
        check("read_r5", rd_data_a, 32'hDEADBEEF);

        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        tick();
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        tick();
        check("read_r0_zero", rd_data_a, 0);

        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_en = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        tick();
        check("bypass_a", rd_data_a, 32'hA5A5A5A5);
        check("bypass_b", rd_data_b, 32'hA5A5A5A5);

        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        check("rsv_r3_count", busy_count, 1);
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 5'd3;
        tick();
        check("r3_busy", busy_a, 1);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        rd_en = 1'b1; rd_addr_a = 5'd3;
        tick();
        check("r3_data", rd_data_a, 32'h55);
        check("r3_busy_clr", busy_a, 0);
        check("r3_count", busy_count, 0);

        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        check("r9_same_count", busy_count, 1);
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 5'd9;
        tick();
        check("r9_still_busy", busy_a, 1);
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd10; tick();
        rsv_addr = 5'd11; tick();
        rsv_addr = 5'd0; tick();
        check("rsv_r0_ignored", busy_count, 3);

        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h1;
        tick();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd6; rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd4;
        tick();
        check("pre_rst_count", busy_count, 5);
        check("pre_rst_busy_b", busy_b, 1);
        check("pre_rst_data_a", rd_data_a, 32'hDEADBEEF);
        idle_inputs();

        // Asynchronous reset between edges must clear outputs immediately.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rd_data_a", rd_data_a, 0);
        check("async_rd_data_b", rd_data_b, 0);
        check("async_busy_a", busy_a, 0);
        check("async_busy_b", busy_b, 0);
        check("async_busy_count", busy_count, 0);
        #2;
        reset_n = 1'b1;
        rd_en = 1'b1; rd_addr_a = 5'd8; rd_addr_b = 5'd4;
        tick();
        check("post_rst_r8", rd_data_a, 0);
        check("post_rst_busy_b", busy_b, 0);
        check("post_rst_count", busy_count, 0);

        for (int c = 0; c < 3000; c++) begin
            bit narrow;
            narrow    = ($urandom_range(0, 3) != 0);
            rd_en     = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 1) != 0);
            rsv_en    = ($urandom_range(0, 2) == 0);
            rd_addr_a = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd_addr_b = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_addr   = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rsv_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data   = DW'($urandom);
            tick();
        end

        idle_inputs();
        @(posedge clock);
        #1;
        compare_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
